// File: rtl/multiplier_32_seq.sv
// Sequential radix-2 Booth multiplier: BITS x BITS -> 2*BITS product as HI/LO words,
// signed (mult) or unsigned (multu), one Booth step per clock.
module multiplier_32_seq #(
  parameter int unsigned BITS = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            is_signed,
  input  logic [BITS-1:0] multiplicand,
  input  logic [BITS-1:0] multiplier,
  output logic [BITS-1:0] product_hi,
  output logic [BITS-1:0] product_lo,
  output logic            busy,
  output logic            done
);

  // Accumulator layout: {upper[BITS:0], lower[BITS:0], booth_bit}.
  localparam int unsigned AccW = 2 * BITS + 3;
  localparam int unsigned CntW = $clog2(BITS + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(BITS);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StCalc   = 2'd1;
  localparam logic [1:0] StFinish = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [AccW-1:0] acc_q, acc_d;
  logic [BITS:0]   mcand_q, mcand_d;
  logic [BITS-1:0] hi_q, hi_d, lo_q, lo_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [BITS:0]   ext_mcand, ext_mplier, upper, sum;
  logic [AccW-1:0] stepped;

  // One Booth step: conditional add/subtract into upper, then arithmetic shift right.
  always_comb begin
    ext_mcand  = {is_signed & multiplicand[BITS-1], multiplicand};
    ext_mplier = {is_signed & multiplier[BITS-1], multiplier};
    upper      = acc_q[AccW-1 -: BITS+1];
    case (acc_q[1:0])
      2'b01:   sum = upper + mcand_q;
      2'b10:   sum = upper - mcand_q;
      default: sum = upper;
    endcase
    stepped = {sum[BITS], sum, acc_q[BITS+1:1]};
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = {{(BITS + 1){1'b0}}, ext_mplier, 1'b0};
          mcand_d = ext_mcand;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = StCalc;
        end
      end
      StCalc: begin
        acc_d   = stepped;
        count_d = count_q + CntW'(1);
        if (count_q == LastCnt) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        hi_d    = acc_q[2*BITS:BITS+1];
        lo_d    = acc_q[BITS:1];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign product_hi = hi_q;
  assign product_lo = lo_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_multiplier_32_seq.sv
// Scoreboard bench for multiplier_32_seq: directed vectors plus random back-to-back operands.
module tb_multiplier_32_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] multiplicand = '0;
  logic [31:0] multiplier = '0;
  logic [31:0] product_hi, product_lo;
  logic        busy, done;

  multiplier_32_seq #(.BITS(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .is_signed    (is_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product_hi   (product_hi),
    .product_lo   (product_lo),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  int          total = 0;
  int          passed = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          issued = 0;
  int          dones = 0;
  logic [63:0] exp_q[$];

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (done) begin
      dones++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", {product_hi, product_lo}, 64'hxxxx_xxxx_xxxx_xxxx);
      end else begin
        check("product", {product_hi, product_lo}, exp_q.pop_front());
      end
    end
  end

  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [63:0] exp);
    is_signed    = s;
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    if (push) begin
      exp_q.push_back(exp);
      issued++;
    end
    @(posedge clock);
    #1;
    start_cyc = cyc;
    start     = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bc);
    bc  = 0;
    lat = -1;
    for (int i = 0; i < 80; i++) begin
      if (done) begin
        lat = cyc - start_cyc;
        break;
      end
      if (busy) bc++;
      @(posedge clock);
      #1;
    end
    if (lat < 0) check("done_timeout", 64'(lat), 64'd34);
  endtask

  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  initial begin : stim
    int lat, bc;
    vec_t vecs[5];
    vecs[0] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[1] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[2] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000};
    vecs[3] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("reset_product", {product_hi, product_lo}, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);

    // 88 x -5 signed, with latency and busy-duration checks.
    issue(1'b1, 32'd88, -32'sd5, 1'b1, 64'hFFFF_FFFF_FFFF_FE48);
    wait_done(lat, bc);
    check("latency_88x-5", 64'(lat), 64'd34);
    check("busy_cycles", 64'(bc), 64'd34);
    check("busy_at_done", 64'(busy), 64'd0);

    foreach (vecs[i]) begin
      issue(vecs[i].s, vecs[i].a, vecs[i].b, 1'b1, vecs[i].p);
      wait_done(lat, bc);
      check("latency_directed", 64'(lat), 64'd34);
    end

    // Start while busy must be ignored.
    issue(1'b0, 32'd7, 32'd6, 1'b1, 64'd42);
    repeat (9) @(posedge clock);
    #1;
    is_signed    = 1'b0;
    multiplicand = 32'd3;
    multiplier   = 32'd3;
    start        = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done(lat, bc);
    check("latency_ignored_start", 64'(lat), 64'd34);
    repeat (45) @(posedge clock);
    #1;
    check("hold_after_ignore", {product_hi, product_lo}, 64'd42);

    // Reset mid-operation discards the result.
    issue(1'b0, 32'd1000, 32'd1000, 1'b0, 64'd0);
    repeat (14) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_product", {product_hi, product_lo}, 64'd0);
    repeat (45) @(posedge clock);
    #1;
    check("abort_no_done_busy", 64'(busy), 64'd0);
    issue(1'b0, 32'd2, 32'd3, 1'b1, 64'd6);
    wait_done(lat, bc);
    check("latency_after_abort", 64'(lat), 64'd34);

    // Random back-to-back: next start issued in the cycle done is high.
    for (int i = 0; i < 200; i++) begin
      logic        s;
      logic [31:0] a, b;
      s = 1'($urandom_range(0, 1));
      a = $urandom();
      b = $urandom();
      if (i % 16 == 0) a = 32'h8000_0000;
      if (i % 16 == 1) b = 32'hFFFF_FFFF;
      issue(s, a, b, 1'b1, ref_mul(s, a, b));
      wait_done(lat, bc);
      if (lat != 34) check("latency_random", 64'(lat), 64'd34);
    end

    repeat (3) @(posedge clock);
    #1;
    check("done_count", 64'(dones), 64'(issued));
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
